// File: rtl/inst_align_pkg.sv
// Shared definitions for the instruction alignment buffer and the decoders.
package inst_align_pkg;

    localparam int HW_W   = 16;
    localparam int INST_W = 32;

    function automatic logic is_com(input logic [HW_W-1:0] hw);
        return hw[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/inst_hw_fifo.sv
// Halfword circular FIFO with 0/1/2 halfword write and read per cycle.
module inst_hw_fifo
    import inst_align_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              clr_i,
    input  logic [1:0]        wr_cnt_i,
    input  logic [2*HW_W-1:0] wr_data_i,
    input  logic [1:0]        rd_cnt_i,
    output logic [HW_W-1:0]   head0_o,
    output logic [HW_W-1:0]   head1_o,
    output logic [CW-1:0]     count_o
);

    logic [HW_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [PW-1:0]   wr_ptr_1;
    logic [PW-1:0]   rd_ptr_1;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [1:0] n);
        int s;
        s = int'(p) + int'(n);
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    assign wr_ptr_1 = ptr_add(wr_ptr_q, 2'd1);
    assign rd_ptr_1 = ptr_add(rd_ptr_q, 2'd1);

    assign head0_o = mem_q[rd_ptr_q];
    assign head1_o = mem_q[rd_ptr_1];
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_cnt_i != 2'd0) mem_q[wr_ptr_q] <= wr_data_i[HW_W-1:0];
            if (wr_cnt_i == 2'd2) mem_q[wr_ptr_1] <= wr_data_i[2*HW_W-1:HW_W];
            wr_ptr_q <= ptr_add(wr_ptr_q, wr_cnt_i);
            rd_ptr_q <= ptr_add(rd_ptr_q, rd_cnt_i);
            count_q  <= count_q + CW'(wr_cnt_i) - CW'(rd_cnt_i);
        end
    end

endmodule

// File: rtl/inst_align.sv
// Fetch-to-decode alignment buffer presenting one RVC or 32-bit instruction per handshake.
// Optional macro INST_ALIGN_ZERO_ILL_EN adds inst_ill_o flagging an all-zero compressed halfword.
module inst_align
    import inst_align_pkg::*;
#(
    parameter int          HW_DEPTH = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [INST_W-1:0] fetch_data_i,
    input  logic              fetch_val_i,
    output logic              fetch_rdy_o,
    input  logic              flush_i,
    input  logic [INST_W-1:0] flush_pc_i,
    output logic [INST_W-1:0] inst_o,
    output logic [INST_W-1:0] inst_pc_o,
    output logic              inst_com_o,
    output logic              inst_val_o,
    input  logic              inst_rdy_i
`ifdef INST_ALIGN_ZERO_ILL_EN
    ,
    output logic              inst_ill_o
`endif
);

    localparam int CW = $clog2(HW_DEPTH + 1);

    logic [CW-1:0]     count;
    logic [HW_W-1:0]   head0;
    logic [HW_W-1:0]   head1;
    logic [INST_W-1:0] pc_q;
    logic              skip_lo_q;
    logic              head_com;
    logic              push;
    logic              pop;
    logic [1:0]        wr_cnt;
    logic [1:0]        rd_cnt;
    logic [INST_W-1:0] wr_data;

    inst_hw_fifo #(
        .DEPTH (HW_DEPTH)
    ) u_fifo (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .clr_i     (flush_i),
        .wr_cnt_i  (wr_cnt),
        .wr_data_i (wr_data),
        .rd_cnt_i  (rd_cnt),
        .head0_o   (head0),
        .head1_o   (head1),
        .count_o   (count)
    );

    // Readiness looks only at the registered count; a same-cycle pop does not help.
    assign fetch_rdy_o = (int'(count) <= HW_DEPTH - 2);
    assign inst_pc_o   = pc_q;

    always_comb begin
        head_com   = is_com(head0);
        inst_com_o = head_com;
        inst_val_o = head_com ? (count >= CW'(1)) : (count >= CW'(2));
        inst_o     = head_com ? {16'h0000, head0} : {head1, head0};

        push = fetch_val_i & fetch_rdy_o & ~flush_i;
        pop  = inst_val_o & inst_rdy_i & ~flush_i;

        // After a redirect to pc[1]=1 the low halfword of the first word is not ours.
        wr_data = skip_lo_q ? {16'h0000, fetch_data_i[31:16]} : fetch_data_i;
        wr_cnt  = push ? (skip_lo_q ? 2'd1 : 2'd2) : 2'd0;
        rd_cnt  = pop ? (head_com ? 2'd1 : 2'd2) : 2'd0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pc_q      <= RESET_PC;
            skip_lo_q <= RESET_PC[1];
        end else if (flush_i) begin
            pc_q      <= flush_pc_i & 32'hFFFF_FFFE;
            skip_lo_q <= flush_pc_i[1];
        end else begin
            if (pop)  pc_q      <= pc_q + (head_com ? 32'd2 : 32'd4);
            if (push) skip_lo_q <= 1'b0;
        end
    end

`ifdef INST_ALIGN_ZERO_ILL_EN
    assign inst_ill_o = inst_val_o & head_com & (head0 == 16'h0000);
`endif

endmodule

// File: tb/tb_inst_align.sv
// Directed bench for inst_align with a halfword-queue reference model checked every cycle.
module tb_inst_align;

    localparam int          DEPTH = 8;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [31:0] fetch_data_i;
    logic        fetch_val_i;
    logic        fetch_rdy_o;
    logic        flush_i;
    logic [31:0] flush_pc_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_com_o;
    logic        inst_val_o;
    logic        inst_rdy_i;
`ifdef INST_ALIGN_ZERO_ILL_EN
    logic        inst_ill_o;
`endif

    int checks   = 0;
    int failures = 0;

    inst_align #(
        .HW_DEPTH (DEPTH),
        .RESET_PC (RPC)
    ) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .fetch_data_i (fetch_data_i),
        .fetch_val_i  (fetch_val_i),
        .fetch_rdy_o  (fetch_rdy_o),
        .flush_i      (flush_i),
        .flush_pc_i   (flush_pc_i),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_com_o   (inst_com_o),
        .inst_val_o   (inst_val_o),
        .inst_rdy_i   (inst_rdy_i)
`ifdef INST_ALIGN_ZERO_ILL_EN
        ,
        .inst_ill_o   (inst_ill_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the buffered halfwords as a plain queue.
    logic [15:0] mq[$];
    logic [31:0] m_pc   = RPC;
    logic        m_skip = RPC[1];
    logic        m_rdy;
    int          m_n;
    int          c_n;

    // Halfwords making up the head instruction; 0 when none is complete.
    function automatic int head_len();
        if (mq.size() == 0) return 0;
        if (mq[0][1:0] != 2'b11) return 1;
        if (mq.size() >= 2) return 2;
        return 0;
    endfunction

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mq.delete();
            m_pc   = RPC;
            m_skip = RPC[1];
        end else if (flush_i) begin
            mq.delete();
            m_pc   = flush_pc_i & 32'hFFFF_FFFE;
            m_skip = flush_pc_i[1];
        end else begin
            m_rdy = (mq.size() <= DEPTH - 2);
            m_n   = head_len();
            if (m_n != 0 && inst_rdy_i) begin
                for (int k = 0; k < m_n; k++) void'(mq.pop_front());
                m_pc = m_pc + 32'(2 * m_n);
            end
            if (fetch_val_i && m_rdy) begin
                if (!m_skip) mq.push_back(fetch_data_i[15:0]);
                mq.push_back(fetch_data_i[31:16]);
                m_skip = 1'b0;
            end
        end
    end

    always @(negedge clk_i) begin
        if (rst_n_i) begin
            c_n = head_len();
            check("m_rdy", fetch_rdy_o, 32'(mq.size() <= DEPTH - 2));
            check("m_val", inst_val_o, 32'(c_n != 0));
            check("m_pc", inst_pc_o, m_pc);
            if (c_n == 1) begin
                check("m_inst", inst_o, {16'h0000, mq[0]});
                check("m_com", inst_com_o, 32'd1);
            end else if (c_n == 2) begin
                check("m_inst", inst_o, {mq[1], mq[0]});
                check("m_com", inst_com_o, 32'd0);
            end
`ifdef INST_ALIGN_ZERO_ILL_EN
            check("m_ill", inst_ill_o, 32'(c_n == 1 && mq[0] == 16'h0000));
`endif
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #2;
    endtask

    task automatic flush_to(input logic [31:0] pc);
        flush_i    = 1'b1;
        flush_pc_i = pc;
        tick();
        flush_i    = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] d);
        fetch_val_i  = 1'b1;
        fetch_data_i = d;
        tick();
        fetch_val_i  = 1'b0;
    endtask

    initial begin
        rst_n_i      = 1'b0;
        fetch_data_i = '0;
        fetch_val_i  = 1'b0;
        flush_i      = 1'b0;
        flush_pc_i   = '0;
        inst_rdy_i   = 1'b0;

        tick();
        check("rst_val", inst_val_o, 32'd0);
        check("rst_rdy", fetch_rdy_o, 32'd1);
        check("rst_pc", inst_pc_o, 32'd0);
        tick();
        rst_n_i = 1'b1;
        tick();

        // aligned 32-bit
        push_word(32'h00A0_0093);
        check("t1_val", inst_val_o, 32'd1);
        check("t1_com", inst_com_o, 32'd0);
        check("t1_inst", inst_o, 32'h00A0_0093);
        check("t1_pc", inst_pc_o, 32'd0);
        inst_rdy_i = 1'b1;
        tick();
        inst_rdy_i = 1'b0;
        check("t1_pc_pop", inst_pc_o, 32'd4);
        check("t1_val_pop", inst_val_o, 32'd0);

        // two compressed
        flush_to(32'd0);
        check("t2_flush_pc", inst_pc_o, 32'd0);
        inst_rdy_i = 1'b1;
        push_word(32'h0001_0001);
        check("t2_inst0", inst_o, 32'h0000_0001);
        check("t2_com0", inst_com_o, 32'd1);
        check("t2_pc0", inst_pc_o, 32'd0);
        tick();
        check("t2_inst1", inst_o, 32'h0000_0001);
        check("t2_val1", inst_val_o, 32'd1);
        check("t2_pc1", inst_pc_o, 32'd2);
        tick();
        check("t2_empty", inst_val_o, 32'd0);
        check("t2_pc_end", inst_pc_o, 32'd4);
        inst_rdy_i = 1'b0;

        // straddling 32-bit
        flush_to(32'd0);
        inst_rdy_i = 1'b1;
        push_word(32'h0093_0001);
        check("t3_nop", inst_o, 32'h0000_0001);
        check("t3_nop_pc", inst_pc_o, 32'd0);
        tick();
        check("t3_wait", inst_val_o, 32'd0);
        check("t3_wait_pc", inst_pc_o, 32'd2);
        tick();
        check("t3_wait2", inst_val_o, 32'd0);
        push_word(32'h0000_00A0);
        check("t3_inst", inst_o, 32'h00A0_0093);
        check("t3_com", inst_com_o, 32'd0);
        check("t3_pc", inst_pc_o, 32'd2);
        tick();
        check("t3_tail", inst_o, 32'h0000_0000);
        check("t3_tail_pc", inst_pc_o, 32'd6);
        tick();
        check("t3_done", inst_val_o, 32'd0);
        check("t3_done_pc", inst_pc_o, 32'd8);
        inst_rdy_i = 1'b0;

        // flush with skip-low, simultaneous push dropped
        push_word(32'h1111_1113);
        check("t4_buf", inst_val_o, 32'd1);
        fetch_val_i  = 1'b1;
        fetch_data_i = 32'hDEAD_BEEF;
        flush_to(32'h0000_0102);
        fetch_val_i  = 1'b0;
        check("t4_val", inst_val_o, 32'd0);
        check("t4_pc", inst_pc_o, 32'h0000_0102);
        check("t4_rdy", fetch_rdy_o, 32'd1);
        push_word(32'h0005_0001);
        check("t4_inst", inst_o, 32'h0000_0005);
        check("t4_com", inst_com_o, 32'd1);
        check("t4_pc2", inst_pc_o, 32'h0000_0102);
        inst_rdy_i = 1'b1;
        tick();
        inst_rdy_i = 1'b0;
        check("t4_one", inst_val_o, 32'd0);
        check("t4_pc3", inst_pc_o, 32'h0000_0104);

        // fill to capacity, then overlapped push/pop, then drain
        flush_to(32'd0);
        fetch_val_i  = 1'b1;
        fetch_data_i = 32'h0000_0000;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t5_rdy", fetch_rdy_o, 32'(i < 3));
        end
        check("t5_inst", inst_o, 32'h0000_0000);
        check("t5_com", inst_com_o, 32'd1);
`ifdef INST_ALIGN_ZERO_ILL_EN
        check("t5_ill", inst_ill_o, 32'd1);
`endif
        tick();
        tick();
        check("t5_full", fetch_rdy_o, 32'd0);
        fetch_data_i = 32'h4501_0513;
        inst_rdy_i   = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        fetch_val_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("t5_drained", inst_val_o, 32'd0);
        inst_rdy_i = 1'b0;

        // asynchronous reset mid-operation
        push_word(32'h00A0_0093);
        check("t6_buf", inst_val_o, 32'd1);
        rst_n_i = 1'b0;
        #1;
        check("t6_val", inst_val_o, 32'd0);
        check("t6_rdy", fetch_rdy_o, 32'd1);
        check("t6_pc", inst_pc_o, 32'd0);
        tick();
        rst_n_i = 1'b1;
        tick();
        check("t6_after", inst_val_o, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
